// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
//  - Latches decoded operands/control from ID every cycle.
//  - Resolves EX/MEM and MEM/WB forwarding combinationally on the latched
//    rs1/rs2 addresses and drives the final ALU operands.
//  - Detects load-use hazards, stalls IF/ID and injects one bubble into EX.
// Update priority per edge: reset > flush > stall > load-use bubble > load.
// Optional: define IDEX_PERF_CNT_EN to add saturating forward/bubble counters
// (o_fwd_cnt, o_bubble_cnt).
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [RA_W-1:0] i_rs1_addr,
  input  logic [RA_W-1:0] i_rs2_addr,
  input  logic [RA_W-1:0] i_rd_addr,
  input  logic            i_rd_wren,
  input  logic            i_mem_rden,
  input  logic [3:0]      i_alu_op,
  input  logic            i_br_un,
  input  logic            i_opa_sel,
  input  logic            i_opb_sel,
  input  logic [RA_W-1:0] i_exmem_rd_addr,
  input  logic            i_exmem_rd_wren,
  input  logic [XLEN-1:0] i_exmem_data,
  input  logic [RA_W-1:0] i_memwb_rd_addr,
  input  logic            i_memwb_rd_wren,
  input  logic [XLEN-1:0] i_memwb_data,
  output logic [XLEN-1:0] o_op_a,
  output logic [XLEN-1:0] o_op_b,
  output logic [3:0]      o_alu_op,
  output logic            o_br_un,
  output logic [XLEN-1:0] o_store_data,
  output logic [XLEN-1:0] o_pc,
  output logic [RA_W-1:0] o_rd_addr,
  output logic            o_rd_wren,
  output logic            o_mem_rden,
  output logic            o_valid,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]     o_fwd_cnt,
  output logic [31:0]     o_bubble_cnt,
`endif
  output logic            o_load_use_stall
);

  // Everything the stage carries from ID into EX.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic            rd_wren;
    logic            mem_rden;
    logic [3:0]      alu_op;
    logic            br_un;
    logic            opa_sel;
    logic            opb_sel;
  } stage_t;

  stage_t stage_q, stage_d;

  logic            load_use;
  logic            rs1_ex_hit, rs1_wb_hit, rs2_ex_hit, rs2_wb_hit;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Load in EX whose rd is read by the valid instruction sitting in ID.
  assign load_use = stage_q.valid & stage_q.mem_rden & (stage_q.rd_addr != '0) & i_valid &
                    ((stage_q.rd_addr == i_rs1_addr) | (stage_q.rd_addr == i_rs2_addr));

  // Forward hits; x0 is excluded so a write to x0 never leaks into an operand.
  assign rs1_ex_hit = i_exmem_rd_wren & (i_exmem_rd_addr != '0) & (i_exmem_rd_addr == stage_q.rs1_addr);
  assign rs1_wb_hit = i_memwb_rd_wren & (i_memwb_rd_addr != '0) & (i_memwb_rd_addr == stage_q.rs1_addr);
  assign rs2_ex_hit = i_exmem_rd_wren & (i_exmem_rd_addr != '0) & (i_exmem_rd_addr == stage_q.rs2_addr);
  assign rs2_wb_hit = i_memwb_rd_wren & (i_memwb_rd_addr != '0) & (i_memwb_rd_addr == stage_q.rs2_addr);

  // Forwarding mux per operand: the younger EX/MEM result beats MEM/WB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fwd_rs1 = stage_q.rs1_data;
    fwd_rs2 = stage_q.rs2_data;
    if (rs1_ex_hit)      fwd_rs1 = i_exmem_data;
    else if (rs1_wb_hit) fwd_rs1 = i_memwb_data;
    if (rs2_ex_hit)      fwd_rs2 = i_exmem_data;
    else if (rs2_wb_hit) fwd_rs2 = i_memwb_data;
  end

  // Next-state selection: flush > stall > bubble > load.
  always_comb begin
    stage_d = stage_q;
    if (i_flush || (!i_stall && load_use)) begin
      // Kill: only the control bits matter, data fields are left as-is.
      stage_d.valid    = 1'b0;
      stage_d.rd_wren  = 1'b0;
      stage_d.mem_rden = 1'b0;
    end else if (!i_stall) begin
      stage_d.valid    = i_valid;
      stage_d.pc       = i_pc;
      stage_d.rs1_data = i_rs1_data;
      stage_d.rs2_data = i_rs2_data;
      stage_d.imm      = i_imm;
      stage_d.rs1_addr = i_rs1_addr;
      stage_d.rs2_addr = i_rs2_addr;
      stage_d.rd_addr  = i_rd_addr;
      stage_d.rd_wren  = i_rd_wren & i_valid;
      stage_d.mem_rden = i_mem_rden & i_valid;
      stage_d.alu_op   = i_alu_op;
      stage_d.br_un    = i_br_un;
      stage_d.opa_sel  = i_opa_sel;
      stage_d.opb_sel  = i_opb_sel;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_reset) stage_q <= '0;
    else         stage_q <= stage_d;
  end

  assign o_op_a           = stage_q.opa_sel ? stage_q.pc  : fwd_rs1;
  assign o_op_b           = stage_q.opb_sel ? stage_q.imm : fwd_rs2;
  assign o_store_data     = fwd_rs2;
  assign o_alu_op         = stage_q.alu_op;
  assign o_br_un          = stage_q.br_un;
  assign o_pc             = stage_q.pc;
  assign o_rd_addr        = stage_q.rd_addr;
  assign o_rd_wren        = stage_q.rd_wren;
  assign o_mem_rden       = stage_q.mem_rden;
  assign o_valid          = stage_q.valid;
  assign o_load_use_stall = load_use;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] fwd_cnt_q, bubble_cnt_q;
  logic [1:0]  fwd_inc;
  logic [32:0] fwd_sum;
  logic        bubble_ins;

  assign fwd_inc    = {1'b0, rs1_ex_hit | rs1_wb_hit} + {1'b0, rs2_ex_hit | rs2_wb_hit};
  assign fwd_sum    = {1'b0, fwd_cnt_q} + {31'd0, fwd_inc};
  assign bubble_ins = load_use & ~i_flush & ~i_stall;

  // Saturating event counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fwd_cnt_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stage_q.valid && !i_stall)
        fwd_cnt_q <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      if (bubble_ins && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign o_fwd_cnt    = fwd_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. Expected EX-side results are pushed to a
// scoreboard queue when ID stimulus is driven and popped after the capturing edge.
// Define IDEX_PERF_CNT_EN to also check the performance counters.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, flush, stall;
  logic [31:0] pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_wren, mem_rden, br_un, opa_sel, opb_sel;
  logic [3:0]  alu_op;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_wren, memwb_wren;
  logic [31:0] exmem_data, memwb_data;

  logic [31:0] op_a, op_b, store_data, pc_o;
  logic [3:0]  alu_op_o;
  logic        br_un_o, rd_wren_o, mem_rden_o, valid_o, lu_stall;
  logic [4:0]  rd_addr_o;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] fwd_cnt, bubble_cnt;
  logic [31:0] cnt0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    bit          ctrl_only;
    logic        valid, rd_wren, mem_rden, br_un;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [31:0] a, b, st, pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_flush(flush), .i_stall(stall),
    .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr),
    .i_rd_wren(rd_wren), .i_mem_rden(mem_rden), .i_alu_op(alu_op), .i_br_un(br_un),
    .i_opa_sel(opa_sel), .i_opb_sel(opb_sel),
    .i_exmem_rd_addr(exmem_rd), .i_exmem_rd_wren(exmem_wren), .i_exmem_data(exmem_data),
    .i_memwb_rd_addr(memwb_rd), .i_memwb_rd_wren(memwb_wren), .i_memwb_data(memwb_data),
    .o_op_a(op_a), .o_op_b(op_b), .o_alu_op(alu_op_o), .o_br_un(br_un_o),
    .o_store_data(store_data), .o_pc(pc_o), .o_rd_addr(rd_addr_o),
    .o_rd_wren(rd_wren_o), .o_mem_rden(mem_rden_o), .o_valid(valid_o),
`ifdef IDEX_PERF_CNT_EN
    .o_fwd_cnt(fwd_cnt), .o_bubble_cnt(bubble_cnt),
`endif
    .o_load_use_stall(lu_stall)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one rising edge; sample and drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_drive(input logic v, input logic [31:0] p, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] im,
                          input logic [4:0] rd, input logic wr, input logic mr, input logic [3:0] alu,
                          input logic bu, input logic sa, input logic sb_sel);
    valid = v; pc = p; rs1_addr = r1; rs1_data = d1; rs2_addr = r2; rs2_data = d2; imm = im;
    rd_addr = rd; rd_wren = wr; mem_rden = mr; alu_op = alu; br_un = bu; opa_sel = sa; opb_sel = sb_sel;
  endtask

  task automatic fwd_drive(input logic [4:0] er, input logic ew, input logic [31:0] ed,
                           input logic [4:0] wr, input logic ww, input logic [31:0] wd);
    exmem_rd = er; exmem_wren = ew; exmem_data = ed;
    memwb_rd = wr; memwb_wren = ww; memwb_data = wd;
  endtask

  task automatic push_exp(input string tag, input bit ctrl_only, input logic v, input logic wr,
                          input logic mr, input logic [4:0] rd, input logic [3:0] alu, input logic bu,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                          input logic [31:0] p);
    exp_t e;
    e.tag = tag; e.ctrl_only = ctrl_only; e.valid = v; e.rd_wren = wr; e.mem_rden = mr;
    e.rd = rd; e.alu = alu; e.br_un = bu; e.a = a; e.b = b; e.st = st; e.pc = p;
    sb.push_back(e);
  endtask

  task automatic compare_ex();
    exp_t e;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, ".valid"},    32'(valid_o),    32'(e.valid));
    check({e.tag, ".rd_wren"},  32'(rd_wren_o),  32'(e.rd_wren));
    check({e.tag, ".mem_rden"}, 32'(mem_rden_o), 32'(e.mem_rden));
    if (!e.ctrl_only) begin
      check({e.tag, ".op_a"},  op_a,             e.a);
      check({e.tag, ".op_b"},  op_b,             e.b);
      check({e.tag, ".store"}, store_data,       e.st);
      check({e.tag, ".pc"},    pc_o,             e.pc);
      check({e.tag, ".rd"},    32'(rd_addr_o),   32'(e.rd));
      check({e.tag, ".alu"},   32'(alu_op_o),    32'(e.alu));
      check({e.tag, ".br_un"}, 32'(br_un_o),     32'(e.br_un));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    id_drive(1, 32'h80, 5'd1, 32'h11, 5'd2, 32'h22, 32'h33, 5'd3, 1, 1, 4'd5, 1, 1, 1);
    fwd_drive(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);

    // Reset held two cycles with a valid instruction presented.
    push_exp("reset", 0, 0, 0, 0, 5'd0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    compare_ex();
    check("reset.lu_stall", 32'(lu_stall), 32'd0);
`ifdef IDEX_PERF_CNT_EN
    check("reset.fwd_cnt", fwd_cnt, 32'd0);
    check("reset.bubble_cnt", bubble_cnt, 32'd0);
`endif

    // EX/MEM beats MEM/WB for rs1=x5.
    id_drive(1, 32'h40, 5'd5, 32'h1, 5'd6, 32'h22, 32'h0, 5'd8, 1, 0, 4'd0, 0, 0, 0);
    fwd_drive(5'd5, 1, 32'hAA, 5'd5, 1, 32'h55);
    push_exp("exmem_fwd", 0, 1, 1, 0, 5'd8, 4'd0, 0, 32'hAA, 32'h22, 32'h22, 32'h40);
    tick();
    compare_ex();
    exmem_wren = 1'b0; #1;
    check("memwb_fwd.op_a", op_a, 32'h55);
    memwb_wren = 1'b0; #1;
    check("no_fwd.op_a", op_a, 32'h1);

    // x0 is never forwarded.
    id_drive(1, 32'h44, 5'd3, 32'h33, 5'd0, 32'h0, 32'h0, 5'd9, 1, 0, 4'd2, 0, 0, 0);
    fwd_drive(5'd0, 1, 32'hDEAD, 5'd0, 1, 32'hBEEF);
    push_exp("x0_guard", 0, 1, 1, 0, 5'd9, 4'd2, 0, 32'h33, 32'h0, 32'h0, 32'h44);
    tick();
    compare_ex();

    // Load-use: lw x7 then add using x7.
    fwd_drive(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    id_drive(1, 32'h48, 5'd2, 32'h1000, 5'd0, 32'h0, 32'h4, 5'd7, 1, 1, 4'd0, 0, 0, 1);
    push_exp("lw", 0, 1, 1, 1, 5'd7, 4'd0, 0, 32'h1000, 32'h4, 32'h0, 32'h48);
    tick();
    compare_ex();
    id_drive(1, 32'h4C, 5'd7, 32'h0, 5'd9, 32'h9, 32'h0, 5'd10, 1, 0, 4'd0, 0, 0, 0);
    #1;
    check("lu.stall_on", 32'(lu_stall), 32'd1);
    push_exp("lu.bubble", 1, 0, 0, 0, 5'd0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    compare_ex();
    check("lu.stall_off", 32'(lu_stall), 32'd0);
    fwd_drive(5'd0, 0, 32'h0, 5'd7, 1, 32'h1234);
    push_exp("lu.add", 0, 1, 1, 0, 5'd10, 4'd0, 0, 32'h1234, 32'h9, 32'h9, 32'h4C);
    tick();
    compare_ex();
`ifdef IDEX_PERF_CNT_EN
    check("lu.bubble_cnt", bubble_cnt, 32'd1);
`endif

    // Load with rd=x0 is not a hazard.
    fwd_drive(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    id_drive(1, 32'h50, 5'd0, 32'h0, 5'd0, 32'h0, 32'h8, 5'd0, 1, 1, 4'd0, 0, 0, 1);
    push_exp("lw_x0", 0, 1, 1, 1, 5'd0, 4'd0, 0, 32'h0, 32'h8, 32'h0, 32'h50);
    tick();
    compare_ex();
    id_drive(1, 32'h54, 5'd0, 32'h0, 5'd4, 32'h4, 32'h0, 5'd11, 1, 0, 4'd0, 0, 0, 0);
    #1;
    check("lw_x0.stall", 32'(lu_stall), 32'd0);

    // Flush and stall together: flush wins.
    flush = 1'b1; stall = 1'b1;
    push_exp("flush_stall", 1, 0, 0, 0, 5'd0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    compare_ex();
    flush = 1'b0; stall = 1'b0;

    // Load an instruction, then hold it under stall for three edges.
    id_drive(1, 32'h200, 5'd11, 32'hA5A5, 5'd0, 32'h0, 32'h10, 5'd12, 1, 0, 4'd3, 1, 0, 1);
    push_exp("pre_stall", 0, 1, 1, 0, 5'd12, 4'd3, 1, 32'hA5A5, 32'h10, 32'h0, 32'h200);
    tick();
    compare_ex();
    stall = 1'b1;
    id_drive(1, 32'h300, 5'd13, 32'hFFFF, 5'd14, 32'hEEEE, 32'h20, 5'd15, 1, 1, 4'd9, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      push_exp($sformatf("stall%0d", i), 0, 1, 1, 0, 5'd12, 4'd3, 1, 32'hA5A5, 32'h10, 32'h0, 32'h200);
      tick();
      compare_ex();
    end
    stall = 1'b0;

    // Not-valid capture clears rd_wren and mem_rden.
    id_drive(0, 32'h400, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd14, 1, 1, 4'd1, 0, 0, 0);
    push_exp("invalid_cap", 1, 0, 0, 0, 5'd0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    compare_ex();

    // Operand select with both operands forwarded underneath.
    fwd_drive(5'd5, 1, 32'h77, 5'd6, 1, 32'h66);
    id_drive(1, 32'h100, 5'd5, 32'h5, 5'd6, 32'h6, 32'hFFFF_FFFC, 5'd1, 1, 0, 4'd0, 0, 1, 1);
    push_exp("opsel", 0, 1, 1, 0, 5'd1, 4'd0, 0, 32'h100, 32'hFFFF_FFFC, 32'h66, 32'h100);
    tick();
    compare_ex();
`ifdef IDEX_PERF_CNT_EN
    cnt0 = fwd_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      push_exp($sformatf("opsel%0d", i), 0, 1, 1, 0, 5'd1, 4'd0, 0, 32'h100, 32'hFFFF_FFFC, 32'h66, 32'h100);
      tick();
      compare_ex();
    end
`ifdef IDEX_PERF_CNT_EN
    check("fwd_cnt_delta", fwd_cnt - cnt0, 32'd6);
`endif

    // Reset mid-operation discards the in-flight instruction.
    fwd_drive(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    rst = 1'b1;
    push_exp("mid_reset", 0, 0, 0, 0, 5'd0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    compare_ex();
`ifdef IDEX_PERF_CNT_EN
    check("mid_reset.fwd_cnt", fwd_cnt, 32'd0);
    check("mid_reset.bubble_cnt", bubble_cnt, 32'd0);
`endif
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU in the 5-stage pipeline.
- Latches decoded operands and control from ID each cycle.
- Resolves operand forwarding from EX/MEM and MEM/WB, then drives the final ALU operands (op_a, op_b, alu_op, br_unsign).
- Detects load-use hazards, requests an ID/IF stall and inserts a bubble into EX.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  ID holds a valid instruction.
- i_flush  in  1  branch/jump redirect; kill the instruction entering EX.
- i_stall  in  1  downstream hold; freeze stage contents.
- i_pc  in  XLEN  PC of the ID instruction.
- i_rs1_data, i_rs2_data  in  XLEN  register file read data.
- i_imm  in  XLEN  sign-extended immediate.
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  RA_W  register indices.
- i_rd_wren  in  1  instruction writes rd.
- i_mem_rden  in  1  instruction is a load.
- i_alu_op  in  4  ALU select: 0 add … 9 and.
- i_br_un  in  1  unsigned compare.
- i_opa_sel  in  1  0 = rs1, 1 = pc.
- i_opb_sel  in  1  0 = rs2, 1 = imm.
- i_exmem_rd_addr  in  RA_W;  i_exmem_rd_wren  in  1;  i_exmem_data  in  XLEN  EX/MEM ALU result.
- i_memwb_rd_addr  in  RA_W;  i_memwb_rd_wren  in  1;  i_memwb_data  in  XLEN  MEM/WB writeback data.
- o_op_a, o_op_b  out  XLEN  ALU operands.
- o_alu_op  out  4;  o_br_un  out  1.
- o_store_data  out  XLEN  forwarded rs2.
- o_pc  out  XLEN.
- o_rd_addr  out  RA_W;  o_rd_wren  out  1;  o_mem_rden  out  1.
- o_valid  out  1  EX holds a valid instruction.
- o_load_use_stall  out  1  combinational; hold PC and IF/ID.

Behaviour:
- Clock, reset and edges
  - Single clock; all state updates on the rising edge of i_clk.
  - Reset is synchronous and active-high.
- Reset
  - All registers clear to 0; o_valid=0, o_rd_wren=0, o_mem_rden=0.
  - Registered alu_op=0 (add).
- Update priority per edge: reset > i_flush > i_stall > load-use bubble > load.
  - flush: clear valid, rd_wren and mem_rden; data fields don't-care.
  - stall: hold every register unchanged; flush overrides stall when both are asserted.
  - bubble: same effect as flush, asserted while o_load_use_stall=1 and i_stall=0.
  - load: capture all i_* fields; valid <= i_valid.
  - A not-valid capture also forces rd_wren=0 and mem_rden=0.
- Load-use detection, combinational:
  - o_load_use_stall = o_valid & o_mem_rden & (o_rd_addr!=0) & i_valid & (o_rd_addr==i_rs1_addr | o_rd_addr==i_rs2_addr).
  - Exactly one bubble per hazard: after the bubble, o_mem_rden=0, so the stall deasserts on the next cycle.
  - The load's result then arrives through the MEM/WB forward path.
- Forwarding, combinational from the registered rs1/rs2 addresses, evaluated independently per operand:
  - EX/MEM hit = exmem_wren & exmem_rd!=0 & exmem_rd==rs.
  - MEM/WB hit likewise.
  - Priority: EX/MEM > MEM/WB > registered regfile data.
  - x0 is never forwarded; reading x0 yields the latched data, which the regfile guarantees is 0.
- Operand muxing
  - o_op_a = opa_sel ? pc : fwd_rs1.
  - o_op_b = opb_sel ? imm : fwd_rs2.
  - o_store_data = fwd_rs2 always.
- Latency
  - ID to EX outputs: 1 cycle.
  - Forward path: 0 cycles (combinational).
- Stall behaviour
  - While stalled, forwarding is re-evaluated every cycle against the current EX/MEM and MEM/WB inputs.
- Reset mid-operation: in-flight instruction discarded; no partial state survives.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined: adds o_fwd_cnt (32) and o_bubble_cnt (32).
  - o_fwd_cnt increments by the number of operands forwarded (0/1/2) in each cycle with o_valid=1 and i_stall=0.
  - o_bubble_cnt increments on each inserted load-use bubble.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert i_reset 2 cycles with i_valid=1 → o_valid=0, o_rd_wren=0, o_op_a=0, o_alu_op=0.
- EX/MEM forward: EX rs1=x5=0x1, i_exmem_rd_addr=5, wren=1, data=0x0000_00AA, MEM/WB also rd=5 data=0x55 → o_op_a=0xAA (EX/MEM priority).
- x0 guard: rs2=x0, i_exmem_rd_addr=0, wren=1, data=0xDEAD, opb_sel=0 → o_op_b=0, o_store_data=0.
- Load-use: lw x7 in EX (mem_rden=1, rd=7), ID add uses rs1=x7 → o_load_use_stall=1 one cycle; next edge o_valid=0; then add enters and o_op_a=i_memwb_data=0x1234 when MEM/WB rd=7.
- Flush+stall: i_flush=1 and i_stall=1 same cycle → next o_valid=0, o_rd_wren=0; stall alone 3 cycles → outputs held bit-identical.
- Operand select: opa_sel=1 pc=0x100, opb_sel=1 imm=0xFFFF_FFFC, alu_op=0 → o_op_a=0x100, o_op_b=0xFFFF_FFFC; with IDEX_PERF_CNT_EN, 2 forwarded operands for 3 unstalled cycles → o_fwd_cnt=6.
